// File: rtl/eth_pkg.sv
// Shared types and helpers for the RMII receive path blocks.
package eth_pkg;

  typedef enum logic [1:0] {
    SKIP    = 2'd0,
    IDLE    = 2'd1,
    COLLECT = 2'd2,
    WAIT_CK = 2'd3
  } agg_state_t;

  localparam int COUNT_W = 16;

  function automatic int dibits_per_word(input int word_bits);
    return word_bits / 2;
  endfunction

endpackage

// File: rtl/payload_aggregate_if.sv
// Bundle between the firewall/cksum stages, payload_aggregate and the LED logic.
interface payload_aggregate_if
  import eth_pkg::*;
#(
  parameter int WORD_BITS = 32
);
  // Valid-only streams, no ready anywhere: a dibit is consumed on every clk
  // edge with axiiv=1, and axiov is a one-cycle pulse qualifying axiod.
  logic                 axiiv;
  logic [1:0]           axiid;
  logic                 cksum_done;
  logic                 cksum_kill;
  logic                 axiov;
  logic [WORD_BITS-1:0] axiod;
  logic [COUNT_W-1:0]   good_count;
  logic [COUNT_W-1:0]   drop_count;

  modport master (
    output axiiv, axiid, cksum_done, cksum_kill,
    input  axiov, axiod, good_count, drop_count
  );

  modport slave (
    input  axiiv, axiid, cksum_done, cksum_kill,
    output axiov, axiod, good_count, drop_count
  );

endinterface

// File: rtl/payload_aggregate_sat_counter.sv
// Increment-only counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/payload_aggregate.sv
// Captures the first WORD_BITS of each passing frame's payload and commits it
// once the checksum stage reports a good frame; counts good and dropped frames.
module payload_aggregate
  import eth_pkg::*;
#(
  parameter int WORD_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  payload_aggregate_if.slave  bus,
  output agg_state_t          dbg_state
);

  localparam int DPW   = dibits_per_word(WORD_BITS);
  localparam int CNT_W = $clog2(DPW + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  agg_state_t           state;
  logic [WORD_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TMO_W-1:0]     tmo_q;
  logic                 ck_seen;
  logic                 ck_bad;
  logic                 done_q;
  logic                 axiov_q;
  logic [WORD_BITS-1:0] axiod_q;

  logic done_rise;
  logic verdict;
  logic verdict_bad;
  logic full;
  logic commit;
  logic drop;
  logic start;

  always_comb begin
    // Only a fresh rise counts, so a done level left over from the previous
    // frame can never be mistaken for this frame's verdict.
    done_rise   = bus.cksum_done & ~done_q;
    verdict     = ck_seen | done_rise;
    verdict_bad = ck_seen ? ck_bad : bus.cksum_kill;
    full        = (cnt_q == CNT_W'(DPW));
    commit      = 1'b0;
    drop        = 1'b0;
    if (state == WAIT_CK) begin
      if (verdict) begin
        commit = ~verdict_bad & full;
        drop   = verdict_bad | ~full;
      end else begin
        drop   = bus.axiiv | (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
      end
    end
    start = bus.axiiv & ((state == IDLE) | (state == WAIT_CK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SKIP;
      shift_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ck_seen <= 1'b0;
      ck_bad  <= 1'b0;
      done_q  <= 1'b0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
    end else begin
      done_q  <= bus.cksum_done;
      axiov_q <= commit;
      if (commit) begin
        axiod_q <= shift_q;
      end

      if (start) begin
        // A new frame may begin in the same cycle the old one resolves.
        state   <= COLLECT;
        shift_q <= WORD_BITS'(bus.axiid);
        cnt_q   <= CNT_W'(1);
        ck_seen <= 1'b0;
        ck_bad  <= 1'b0;
      end else begin
        case (state)
          SKIP: begin
            if (!bus.axiiv) begin
              state <= IDLE;
            end
          end
          IDLE: begin
          end
          COLLECT: begin
            // cksum sees the frame ahead of the firewall, so its verdict can
            // land while payload is still streaming.
            if (done_rise && !ck_seen) begin
              ck_seen <= 1'b1;
              ck_bad  <= bus.cksum_kill;
            end
            if (bus.axiiv) begin
              if (!full) begin
                shift_q <= (shift_q << 2) | WORD_BITS'(bus.axiid);
                cnt_q   <= cnt_q + CNT_W'(1);
              end
            end else begin
              state <= WAIT_CK;
              tmo_q <= '0;
            end
          end
          WAIT_CK: begin
            if (commit || drop) begin
              state <= IDLE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          default: state <= SKIP;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(COUNT_W)) u_good_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (commit),
    .count (bus.good_count)
  );

  sat_counter #(.WIDTH(COUNT_W)) u_drop_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop),
    .count (bus.drop_count)
  );

  assign bus.axiov = axiov_q;
  assign bus.axiod = axiod_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_payload_aggregate.sv
// Directed bench for payload_aggregate with a queue-based commit scoreboard.
module tb_payload_aggregate;
  import eth_pkg::*;

  logic       eth_refclk;
  logic       rst;
  agg_state_t dbg_state;

  payload_aggregate_if #(.WORD_BITS(32)) bus ();

  payload_aggregate #(
    .WORD_BITS      (32),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk       (eth_refclk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial eth_refclk = 1'b0;
  always #10 eth_refclk = ~eth_refclk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_drop = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // scoreboard monitor: every axiov pulse must match the oldest expected word
  always @(negedge eth_refclk) begin
    if (bus.axiov === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got axiod=%h expected no commit", bus.axiod);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        if (bus.axiod !== w) begin
          errors++;
          $display("FAIL commit_word: got %h expected %h", bus.axiod, w);
        end
      end
    end
  end

  // driver tasks
  task automatic send_frame(input logic [39:0] data, input int n, input int early_at);
    bus.cksum_done = 1'b0;
    bus.cksum_kill = 1'b0;
    @(negedge eth_refclk);
    for (int i = 0; i < n; i++) begin
      bus.axiiv = 1'b1;
      bus.axiid = data[2*(n-1-i) +: 2];
      if (i == early_at) bus.cksum_done = 1'b1;
      @(negedge eth_refclk);
    end
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_good"}, 32'(bus.good_count), 32'(exp_good));
    check({tag, "_drop"}, 32'(bus.drop_count), 32'(exp_drop));
  endtask

  task automatic verdict(input int delay, input logic kill, input logic [31:0] word, input bit good);
    if (good) exp_q.push_back(word);
    repeat (delay) @(negedge eth_refclk);
    bus.cksum_done = 1'b1;
    bus.cksum_kill = kill;
    @(negedge eth_refclk);
    check("commit_pulse", 32'(bus.axiov), 32'(good));
    if (good) exp_good = sat_inc(exp_good);
    else      exp_drop = sat_inc(exp_drop);
    check_counts("verdict");
  endtask

  initial begin
    rst            = 1'b1;
    bus.axiiv      = 1'b0;
    bus.axiid      = 2'b00;
    bus.cksum_done = 1'b0;
    bus.cksum_kill = 1'b0;
    repeat (3) @(negedge eth_refclk);
    rst = 1'b0;
    check("reset_axiov", 32'(bus.axiov), 32'd0);
    check("reset_axiod", bus.axiod, 32'd0);
    check_counts("reset");
    check("reset_state", 32'(dbg_state), 32'(SKIP));
    @(negedge eth_refclk);
    check("skip_to_idle", 32'(dbg_state), 32'(IDLE));

    // good 20-dibit frame, verdict 3 cycles after the end
    send_frame(40'hDEADBEEF_A5, 20, -1);
    verdict(3, 1'b0, 32'hDEADBEEF, 1'b1);

    // same frame, bad FCS
    send_frame(40'hDEADBEEF_A5, 20, -1);
    verdict(3, 1'b1, 32'h0, 1'b0);
    check("kill_axiod_held", bus.axiod, 32'hDEADBEEF);

    // short frame with good FCS, then a good frame
    send_frame(40'h00000_ABCDE, 10, -1);
    verdict(3, 1'b0, 32'h0, 1'b0);
    send_frame({8'h00, 32'h12345678}, 16, -1);
    verdict(3, 1'b0, 32'h12345678, 1'b1);

    // verdict arrives 2 cycles before valid falls
    exp_q.push_back(32'hA5A50F0F);
    send_frame({8'h00, 32'hA5A50F0F}, 16, 14);
    @(negedge eth_refclk);
    check("early_not_yet", 32'(bus.axiov), 32'd0);
    @(negedge eth_refclk);
    check("early_commit", 32'(bus.axiov), 32'd1);
    exp_good = sat_inc(exp_good);
    check_counts("early");

    // no verdict at all: drop exactly 64 cycles after frame end
    send_frame({8'h00, 32'h0BADC0DE}, 16, -1);
    repeat (64) @(negedge eth_refclk);
    check("tmo_not_yet", 32'(bus.drop_count), 32'(exp_drop));
    check("tmo_wait_state", 32'(dbg_state), 32'(WAIT_CK));
    @(negedge eth_refclk);
    exp_drop = sat_inc(exp_drop);
    check("tmo_drop", 32'(bus.drop_count), 32'(exp_drop));
    check("tmo_state", 32'(dbg_state), 32'(IDLE));

    // new frame before the old verdict: old dropped, new one commits
    send_frame({8'h00, 32'hFEEDFACE}, 16, -1);
    send_frame({8'h00, 32'h13579BDF}, 16, -1);
    exp_drop = sat_inc(exp_drop);
    verdict(3, 1'b0, 32'h13579BDF, 1'b1);

    // reset pulsed mid-frame
    bus.cksum_done = 1'b0;
    @(negedge eth_refclk);
    for (int i = 0; i < 16; i++) begin
      bus.axiiv = 1'b1;
      bus.axiid = 2'(i);
      if (i == 5) begin
        #3 rst = 1'b1;
        #2;
        check("async_rst_axiod", bus.axiod, 32'd0);
        check("async_rst_good", 32'(bus.good_count), 32'd0);
        check("async_rst_drop", 32'(bus.drop_count), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'(SKIP));
        #2 rst = 1'b0;
        exp_good = 16'd0;
        exp_drop = 16'd0;
      end
      @(negedge eth_refclk);
    end
    bus.axiiv = 1'b0;
    repeat (3) @(negedge eth_refclk);
    bus.cksum_done = 1'b1;
    repeat (4) @(negedge eth_refclk);
    check_counts("rst_ignored");
    check("rst_ignored_state", 32'(dbg_state), 32'(IDLE));
    send_frame({8'h00, 32'hCAFEF00D}, 16, -1);
    verdict(3, 1'b0, 32'hCAFEF00D, 1'b1);

    // saturation of good_count
    @(negedge eth_refclk);
    force dut.u_good_count.count_q = 16'hFFFE;
    @(negedge eth_refclk);
    release dut.u_good_count.count_q;
    exp_good = 16'hFFFE;
    check("preload_good", 32'(bus.good_count), 32'h0000FFFE);
    send_frame({8'h00, 32'h11112222}, 16, -1);
    verdict(3, 1'b0, 32'h11112222, 1'b1);
    send_frame({8'h00, 32'h33334444}, 16, -1);
    verdict(3, 1'b0, 32'h33334444, 1'b1);
    check("sat_good", 32'(bus.good_count), 32'h0000FFFF);

    repeat (4) @(negedge eth_refclk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
